flee_port_receiver: RTL and testbench
=====================================

Name: flee_port_receiver

Overview:
- Downstream ejection stage attached to one flee output port of the `system` NoC; consumes flits over valid/ready.
- Throttles acceptance with a programmable periodic ready window, emulating a slow consumer.
- Buffers accepted flits in a small FIFO and checks packet framing.
- Reports packet completion, length, error and stall status to the bench/host side.

Parameters:
- DW, `DW, flit width; top 2 bits are flit type.
- DEPTH, 4, FIFO entries; power of two, ≥2.
- PERIOD, 16, ready-throttle period in cycles, ≥1.
- OPEN, 6, number of cycles per period the throttle is open, 1..PERIOD.
- LW, 8, packet-length counter width.
- WDOG_WIN, 10000, stall watchdog window in cycles.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- data_i  in  DW  flit from NoC flee port.
- valid_i  in  1  flit valid.
- ready_o  out  1  receiver ready.
- data_o  out  DW  FIFO head flit.
- valid_o  out  1  FIFO non-empty.
- ready_i  in  1  consumer pop.
- pkt_done_o  out  1  one-cycle pulse: packet closed.
- pkt_len_o  out  LW  length of closed packet, valid with pkt_done_o.
- err_frame_o  out  1  one-cycle pulse: framing violation.
- err_seq_o  out  1  one-cycle pulse: sequence mismatch (optional feature).
- flit_cnt_o  out  32  accepted flits, wraps.
- pkt_cnt_o  out  32  closed packets, wraps.
- stall_o  out  1  sticky starvation flag.

Behaviour:
- Reset: all outputs 0; phase, FIFO pointers and counters 0; FSM IDLE. Asynchronous assert, synchronous-style release.
- Reset mid-packet discards FIFO contents and partial packet state.
- Throttle: phase counts 0..PERIOD-1 and wraps. open = (phase ≥ PERIOD-OPEN).
- ready_o = rstn & open & ~full.
- Accept = valid_i & ready_o. An accepted flit is written to the FIFO the same edge; it is visible on data_o/valid_o next cycle.
- Pop = valid_o & ready_i. Simultaneous push and pop when full is not possible because ready_o is 0. Simultaneous push and pop otherwise keeps the count unchanged.
- Flit type = data_i[DW-1:DW-2]: HEAD=2'b10, BODY=2'b00, TAIL=2'b01, SINGLE=2'b11.
- Framing FSM, evaluated on accept only:
  - IDLE + HEAD -> IN_PKT, len=1.
  - IDLE + SINGLE -> pulse done, len 1.
  - IDLE + BODY/TAIL -> pulse err_frame, stay IDLE.
  - IN_PKT + BODY -> len+1, saturating at 2^LW-1.
  - IN_PKT + TAIL -> len+1, pulse done with the final len, go IDLE.
  - IN_PKT + HEAD -> pulse err_frame, len=1, stay IN_PKT.
  - IN_PKT + SINGLE -> pulse err_frame and done with len 1, go IDLE.
- All flits are enqueued regardless of framing errors.
- pkt_done_o, pkt_len_o and err_frame_o are registered and assert the cycle after the accept edge.
- flit_cnt_o increments on each accept; pkt_cnt_o increments on each done.
- Watchdog: counter clears on accept or when valid_i=0, otherwise increments. When it reaches WDOG_WIN-1, stall_o sets. stall_o clears on the next accept.

Optional Feature:
- Macro: RECV_SEQ_CHECK_EN.
- With the macro defined:
  - HEAD/SINGLE flits carry an 8-bit sequence number in data_i[DW-3:DW-10].
  - The first head after reset loads the expected value; thereafter expected = previous + 1 mod 256.
  - On mismatch, err_seq_o pulses (timing as err_frame_o) and expected resyncs to received+1.
- Without the macro: err_seq_o is tied 0 and no sequence logic is built.

Decomposition:
- Package noc_flit_pkg holds:
  - flit_type_e enum (HEAD/BODY/TAIL/SINGLE);
  - TYPE_MSB/TYPE_LSB and SEQ_MSB/SEQ_LSB localparams derived from `DW;
  - the FSM state enum.
- Sub-module sync_fifo (DW, DEPTH; push/pop/full/empty), instantiated once.
- Throttle, FSM, counters and watchdog live in the top level.

Test Plan:
- Reset, then valid_i held 1 with a continuous HEAD,BODY,BODY,TAIL stream and ready_i=1, PERIOD=16, OPEN=6 -> ready_o high only on phases 10..15; one pkt_done_o pulse with pkt_len_o=4 and pkt_cnt_o=1.
- ready_i=0 with DEPTH=4 and 5 SINGLE flits offered -> 4 accepted, ready_o stays 0 while full; set ready_i=1 -> 5th accepted at the next open phase, order preserved on data_o.
- Stream BODY, HEAD, HEAD, TAIL -> err_frame_o pulses twice (stray BODY, double HEAD); a single pkt_done_o with len 2.
- ready_i=0, FIFO full, valid_i=1 for 10000 cycles -> stall_o=1; raise ready_i -> stall_o clears on the next accept.
- Assert rstn=0 after HEAD,BODY, release, then send TAIL -> err_frame_o pulses, no pkt_done_o, flit_cnt_o=1.
- RECV_SEQ_CHECK_EN defined, sequence numbers 5,6,8 on SINGLE flits -> err_seq_o pulses once on the 8; a following 9 is accepted with no error.

Source files
------------

// File: rtl/noc_flit_pkg.sv
`default_nettype none
// ============================================================================
// noc_flit_pkg : flit type encoding, field positions and receiver FSM states
//                shared by the flee-port receiver slice.
// Revision     : 1.0
// ============================================================================
`ifndef DW
`define DW 32
`endif

package noc_flit_pkg;

  typedef enum logic [1:0] {
    FLIT_BODY   = 2'b00,
    FLIT_TAIL   = 2'b01,
    FLIT_HEAD   = 2'b10,
    FLIT_SINGLE = 2'b11
  } flit_type_e;

  localparam int TYPE_MSB = `DW - 1;
  localparam int TYPE_LSB = `DW - 2;
  localparam int SEQ_MSB  = `DW - 3;
  localparam int SEQ_LSB  = `DW - 10;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_IN_PKT = 1'b1
  } rx_state_e;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// sync_fifo : single-clock FIFO, power-of-two depth, wrap-bit pointers.
//             Head data reads as zero while empty.
// Revision  : 1.0
// ============================================================================
module sync_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          pop_i,
  output logic [DW-1:0] rdata_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW:0]   wptr_q, wptr_d;
  logic [AW:0]   rptr_q, rptr_d;
  logic          do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  assign wptr_d = do_push ? wptr_q + (AW+1)'(1) : wptr_q;
  assign rptr_d = do_pop  ? rptr_q + (AW+1)'(1) : rptr_q;

  assign rdata_o = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/flee_port_receiver.sv
`default_nettype none
// ============================================================================
// flee_port_receiver : throttled NoC ejection port with FIFO, packet framing
//                      check, counters and stall watchdog.
// Optional build     : define RECV_SEQ_CHECK_EN for HEAD/SINGLE sequence check.
// Revision           : 1.0
// ============================================================================
module flee_port_receiver
  import noc_flit_pkg::*;
#(
  parameter int DW       = `DW,
  parameter int DEPTH    = 4,
  parameter int PERIOD   = 16,
  parameter int OPEN     = 6,
  parameter int LW       = 8,
  parameter int WDOG_WIN = 10000
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [DW-1:0] data_i,
  input  logic          valid_i,
  output logic          ready_o,
  output logic [DW-1:0] data_o,
  output logic          valid_o,
  input  logic          ready_i,
  output logic          pkt_done_o,
  output logic [LW-1:0] pkt_len_o,
  output logic          err_frame_o,
  output logic          err_seq_o,
  output logic [31:0]   flit_cnt_o,
  output logic [31:0]   pkt_cnt_o,
  output logic          stall_o
);

  localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int WW = $clog2(WDOG_WIN + 1);

  function automatic logic [LW-1:0] sat_inc(input logic [LW-1:0] v);
    return (v == {LW{1'b1}}) ? v : v + LW'(1);
  endfunction

  logic [PW-1:0] phase_q, phase_d;
  logic          open_win, fifo_full, fifo_empty, accept;
  flit_type_e    ftype;

  assign phase_d  = (phase_q == PW'(PERIOD - 1)) ? '0 : phase_q + PW'(1);
  assign open_win = (phase_q >= PW'(PERIOD - OPEN));
  assign ready_o  = rstn & open_win & ~fifo_full;
  assign accept   = valid_i & ready_o;
  assign valid_o  = ~fifo_empty;
  assign ftype    = flit_type_e'(data_i[TYPE_MSB:TYPE_LSB]);

  // Every accepted flit is stored, framing errors included.
  sync_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (accept),
    .wdata_i (data_i),
    .pop_i   (ready_i),
    .rdata_o (data_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  rx_state_e     state_q, state_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] pkt_len_q, pkt_len_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    pkt_len_d = pkt_len_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    if (accept) begin
      unique case (state_q)
        ST_IDLE: begin
          case (ftype)
            FLIT_HEAD: begin
              state_d = ST_IN_PKT;
              len_d   = LW'(1);
            end
            FLIT_SINGLE: begin
              done_d    = 1'b1;
              pkt_len_d = LW'(1);
            end
            default: err_d = 1'b1;
          endcase
        end
        ST_IN_PKT: begin
          case (ftype)
            FLIT_BODY: len_d = sat_inc(len_q);
            FLIT_TAIL: begin
              done_d    = 1'b1;
              pkt_len_d = sat_inc(len_q);
              len_d     = '0;
              state_d   = ST_IDLE;
            end
            FLIT_HEAD: begin
              err_d = 1'b1;
              len_d = LW'(1);
            end
            default: begin
              err_d     = 1'b1;
              done_d    = 1'b1;
              pkt_len_d = LW'(1);
              len_d     = '0;
              state_d   = ST_IDLE;
            end
          endcase
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  logic [31:0]   flit_cnt_q, pkt_cnt_q;
  logic [WW-1:0] wdog_q, wdog_d;
  logic          stall_q, stall_d, wdog_hit;

  assign wdog_hit = (wdog_q == WW'(WDOG_WIN - 1));

  // Watchdog only runs while a flit is offered but refused.
  always_comb begin
    wdog_d  = wdog_q;
    stall_d = stall_q;
    if (accept || !valid_i) begin
      wdog_d = '0;
    end else if (!wdog_hit) begin
      wdog_d = wdog_q + WW'(1);
    end
    if (accept) begin
      stall_d = 1'b0;
    end else if (wdog_hit) begin
      stall_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      phase_q    <= '0;
      state_q    <= ST_IDLE;
      len_q      <= '0;
      pkt_len_q  <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      flit_cnt_q <= '0;
      pkt_cnt_q  <= '0;
      wdog_q     <= '0;
      stall_q    <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      state_q    <= state_d;
      len_q      <= len_d;
      pkt_len_q  <= pkt_len_d;
      done_q     <= done_d;
      err_q      <= err_d;
      flit_cnt_q <= flit_cnt_q + 32'(accept);
      pkt_cnt_q  <= pkt_cnt_q + 32'(done_d);
      wdog_q     <= wdog_d;
      stall_q    <= stall_d;
    end
  end

  assign pkt_done_o  = done_q;
  assign pkt_len_o   = pkt_len_q;
  assign err_frame_o = err_q;
  assign flit_cnt_o  = flit_cnt_q;
  assign pkt_cnt_o   = pkt_cnt_q;
  assign stall_o     = stall_q;

`ifdef RECV_SEQ_CHECK_EN
  logic [7:0] seq_exp_q, seq_exp_d, rx_seq;
  logic       seq_vld_q, seq_vld_d, seq_err_q, seq_err_d, seq_flit;

  assign rx_seq   = data_i[SEQ_MSB:SEQ_LSB];
  assign seq_flit = accept & ((ftype == FLIT_HEAD) | (ftype == FLIT_SINGLE));

  // The first numbered flit after reset only seeds the expectation.
  always_comb begin
    seq_exp_d = seq_exp_q;
    seq_vld_d = seq_vld_q;
    seq_err_d = 1'b0;
    if (seq_flit) begin
      seq_err_d = seq_vld_q && (rx_seq != seq_exp_q);
      seq_exp_d = rx_seq + 8'd1;
      seq_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      seq_exp_q <= '0;
      seq_vld_q <= 1'b0;
      seq_err_q <= 1'b0;
    end else begin
      seq_exp_q <= seq_exp_d;
      seq_vld_q <= seq_vld_d;
      seq_err_q <= seq_err_d;
    end
  end

  assign err_seq_o = seq_err_q;
`else
  assign err_seq_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_flee_port_receiver.sv
`default_nettype none
// ============================================================================
// tb_flee_port_receiver : table-driven bench with a cycle model and a data
//                         scoreboard for flee_port_receiver.
// Revision              : 1.0
// ============================================================================
`ifndef DW
`define DW 32
`endif

module tb_flee_port_receiver;
  import noc_flit_pkg::*;

  localparam int DW       = `DW;
  localparam int DEPTH    = 4;
  localparam int PERIOD   = 16;
  localparam int OPEN     = 6;
  localparam int LW       = 8;
  localparam int WDOG_WIN = 10000;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [DW-1:0] data_i = '0;
  logic          valid_i = 1'b0;
  logic          ready_i = 1'b0;
  logic          ready_o, valid_o, pkt_done_o, err_frame_o, err_seq_o, stall_o;
  logic [DW-1:0] data_o;
  logic [LW-1:0] pkt_len_o;
  logic [31:0]   flit_cnt_o, pkt_cnt_o;

  always #5 clk = ~clk;

  flee_port_receiver #(
    .DW       (DW),
    .DEPTH    (DEPTH),
    .PERIOD   (PERIOD),
    .OPEN     (OPEN),
    .LW       (LW),
    .WDOG_WIN (WDOG_WIN)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .data_i      (data_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .pkt_done_o  (pkt_done_o),
    .pkt_len_o   (pkt_len_o),
    .err_frame_o (err_frame_o),
    .err_seq_o   (err_seq_o),
    .flit_cnt_o  (flit_cnt_o),
    .pkt_cnt_o   (pkt_cnt_o),
    .stall_o     (stall_o)
  );

  typedef struct {
    logic [1:0] t;
    logic [7:0] seq;
    bit         err;
    bit         done;
    int         len;
    bit         serr;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [DW-1:0] sb[$];
  int            m_phase;
  bit            m_ready;
  logic [31:0]   m_flit, m_pkt;
  int            m_wd;
  bit            m_stall;
  bit            e_done, e_err, e_seq;
  logic [LW-1:0] e_len;
  bit            f_err, f_done, f_serr;
  logic [LW-1:0] f_len;
  bit            last_acc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_phase = 0;
    m_flit  = '0;
    m_pkt   = '0;
    m_wd    = 0;
    m_stall = 0;
    e_done  = 0;
    e_err   = 0;
    e_seq   = 0;
    e_len   = '0;
  endtask

  task automatic check_outputs();
    chk("ready_o", ready_o, m_ready);
    chk("valid_o", valid_o, sb.size() > 0);
    chk("data_o", data_o, (sb.size() > 0) ? 64'(sb[0]) : 64'd0);
    chk("pkt_done_o", pkt_done_o, e_done);
    if (e_done) chk("pkt_len_o", pkt_len_o, e_len);
    chk("err_frame_o", err_frame_o, e_err);
    chk("err_seq_o", err_seq_o, e_seq);
    chk("flit_cnt_o", flit_cnt_o, m_flit);
    chk("pkt_cnt_o", pkt_cnt_o, m_pkt);
    chk("stall_o", stall_o, m_stall);
  endtask

  // One clock: compare at the falling edge, advance the model after the rising edge.
  task automatic tick();
    bit acc, pop;
    @(negedge clk);
    m_ready = rstn && (m_phase >= PERIOD - OPEN) && (sb.size() < DEPTH);
    check_outputs();
    acc = valid_i && m_ready;
    pop = (sb.size() > 0) && ready_i;
    last_acc = acc;
    @(posedge clk);
    #1;
    if (!rstn) begin
      model_reset();
    end else begin
      if (pop) sb.delete(0);
      if (acc) sb.push_back(data_i);
      m_phase = (m_phase + 1) % PERIOD;
      if (acc) m_flit = m_flit + 1;
      e_done = acc && f_done;
      e_err  = acc && f_err;
`ifdef RECV_SEQ_CHECK_EN
      e_seq  = acc && f_serr;
`else
      e_seq  = 1'b0;
`endif
      if (e_done) begin
        e_len = f_len;
        m_pkt = m_pkt + 1;
      end
      if (acc) m_stall = 0;
      else if (m_wd == WDOG_WIN - 1) m_stall = 1;
      if (acc || !valid_i) m_wd = 0;
      else if (m_wd != WDOG_WIN - 1) m_wd = m_wd + 1;
    end
  endtask

  task automatic do_reset();
    valid_i = 1'b0;
    rstn    = 1'b0;
    model_reset();
    repeat (3) tick();
    rstn = 1'b1;
  endtask

  task automatic offer(input logic [1:0] t, input logic [7:0] seq, input logic [15:0] pl,
                       input bit err, input bit done, input int len, input bit serr);
    logic [DW-1:0] d;
    d = '0;
    d[TYPE_MSB:TYPE_LSB] = t;
    d[SEQ_MSB:SEQ_LSB]   = seq;
    d[15:0]              = pl;
    data_i  = d;
    valid_i = 1'b1;
    f_err   = err;
    f_done  = done;
    f_len   = LW'(len);
    f_serr  = serr;
  endtask

  task automatic wait_accept(input string name, input int budget);
    int n;
    n = 0;
    last_acc = 0;
    while (!last_acc && n < budget) begin
      tick();
      n++;
    end
    chk(name, last_acc, 1);
    valid_i = 1'b0;
  endtask

  task automatic send_flit(input vec_t v, input logic [15:0] pl);
    offer(v.t, v.seq, pl, v.err, v.done, v.len, v.serr);
    wait_accept("accept_timeout", 4 * PERIOD);
  endtask

  vec_t tbl[10];
  vec_t seqv[4];
  vec_t one;
  int   n_acc;

  initial begin
    // HEAD,BODY,BODY,TAIL then stray BODY, double HEAD, HEAD+SINGLE
    tbl[0] = '{FLIT_HEAD,   8'd0, 0, 0, 0, 0};
    tbl[1] = '{FLIT_BODY,   8'd0, 0, 0, 0, 0};
    tbl[2] = '{FLIT_BODY,   8'd0, 0, 0, 0, 0};
    tbl[3] = '{FLIT_TAIL,   8'd0, 0, 1, 4, 0};
    tbl[4] = '{FLIT_BODY,   8'd0, 1, 0, 0, 0};
    tbl[5] = '{FLIT_HEAD,   8'd1, 0, 0, 0, 0};
    tbl[6] = '{FLIT_HEAD,   8'd2, 1, 0, 0, 0};
    tbl[7] = '{FLIT_TAIL,   8'd0, 0, 1, 2, 0};
    tbl[8] = '{FLIT_HEAD,   8'd3, 0, 0, 0, 0};
    tbl[9] = '{FLIT_SINGLE, 8'd4, 1, 1, 1, 0};
    seqv[0] = '{FLIT_SINGLE, 8'd5, 0, 1, 1, 0};
    seqv[1] = '{FLIT_SINGLE, 8'd6, 0, 1, 1, 0};
`ifdef RECV_SEQ_CHECK_EN
    seqv[2] = '{FLIT_SINGLE, 8'd8, 0, 1, 1, 1};
`else
    seqv[2] = '{FLIT_SINGLE, 8'd8, 0, 1, 1, 0};
`endif
    seqv[3] = '{FLIT_SINGLE, 8'd9, 0, 1, 1, 0};

    // Streaming packet with throttled ready, then framing errors
    do_reset();
    ready_i = 1'b1;
    for (int i = 0; i < 4; i++) send_flit(tbl[i], 16'(16'hA000 + i));
    chk("stream_done", pkt_done_o, 1);
    chk("stream_len", pkt_len_o, 4);
    chk("stream_pkt_cnt", pkt_cnt_o, 1);
    for (int i = 4; i < 10; i++) send_flit(tbl[i], 16'(16'hB000 + i));
    repeat (4) tick();

    // FIFO full backpressure and ordering
    do_reset();
    ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      one = '{FLIT_SINGLE, 8'(i), 0, 1, 1, 0};
      send_flit(one, 16'(16'hC000 + i));
    end
    offer(FLIT_SINGLE, 8'd4, 16'hC004, 0, 1, 1, 0);
    n_acc = 0;
    repeat (40) begin
      tick();
      if (last_acc) n_acc++;
    end
    chk("full_blocks_accept", n_acc, 0);
    chk("ready_low_while_full", ready_o, 0);
    ready_i = 1'b1;
    wait_accept("fifth_accepted", 4 * PERIOD);
    repeat (8) tick();
    chk("fifo_drained", valid_o, 0);

    // Stall watchdog
    do_reset();
    ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      one = '{FLIT_SINGLE, 8'(i), 0, 1, 1, 0};
      send_flit(one, 16'(16'hD000 + i));
    end
    offer(FLIT_SINGLE, 8'd4, 16'hD004, 0, 1, 1, 0);
    repeat (WDOG_WIN + 5) tick();
    chk("stall_set", stall_o, 1);
    ready_i = 1'b1;
    wait_accept("stall_flit_accepted", 4 * PERIOD);
    chk("stall_clear", stall_o, 0);
    repeat (8) tick();

    // Reset in the middle of a packet
    do_reset();
    ready_i = 1'b1;
    send_flit(tbl[0], 16'hE000);
    send_flit(tbl[1], 16'hE001);
    do_reset();
    one = '{FLIT_TAIL, 8'd0, 1, 0, 0, 0};
    send_flit(one, 16'hE002);
    chk("tail_after_reset_err", err_frame_o, 1);
    chk("tail_after_reset_nodone", pkt_done_o, 0);
    chk("flit_cnt_after_reset", flit_cnt_o, 1);
    repeat (4) tick();

    // Sequence numbers 5,6,8,9
    do_reset();
    ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_flit(seqv[i], 16'(16'hF000 + i));
      chk("seq_err_pulse", err_seq_o, seqv[i].serr);
    end
    repeat (8) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
